// File: rtl/wt_wbuf_pkg.sv
// Shared types for the write-through store buffer: entry state, entry record and word-address helper.
// Entry field widths follow WB_ADDR_W / WB_DATA_W; the top-level width parameters must match them.
package wt_wbuf_pkg;

    localparam int WB_ADDR_W  = 34;
    localparam int WB_DATA_W  = 64;
    localparam int WB_BE_W    = WB_DATA_W / 8;
    localparam int WB_WADDR_W = WB_ADDR_W - 3;

    typedef enum logic [1:0] {
        WB_FREE,
        WB_VALID,
        WB_SENT
    } wbuf_state_e;

    typedef struct packed {
        wbuf_state_e             state;
        logic [WB_WADDR_W-1:0]   waddr;
        logic [WB_DATA_W-1:0]    data;
        logic [WB_BE_W-1:0]      be;
        logic                    nc;
    } wbuf_entry_t;

    function automatic logic [WB_WADDR_W-1:0] word_addr(input logic [WB_ADDR_W-1:0] paddr);
        return paddr[WB_ADDR_W-1:3];
    endfunction

endpackage

// File: rtl/wt_wbuf_entry.sv
// One store-buffer slot: state register, byte-merge datapath and the two word-address comparators.
module wt_wbuf_entry
    import wt_wbuf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc,
    input  logic                  merge,
    input  logic                  issue,
    input  logic                  ack,
    input  logic [WB_WADDR_W-1:0] wr_waddr,
    input  logic [WB_DATA_W-1:0]  wr_data,
    input  logic [WB_BE_W-1:0]    wr_be,
    input  logic                  wr_nc,
    input  logic [WB_WADDR_W-1:0] chk_waddr,
    output wbuf_entry_t           entry,
    output logic                  merge_match,
    output logic                  chk_match
);

    wbuf_entry_t q;

    // alloc/merge/issue/ack are mutually exclusive per slot because each needs a different current state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            if (alloc) begin
                q.state <= WB_VALID;
                q.waddr <= wr_waddr;
                q.data  <= wr_data;
                q.be    <= wr_be;
                q.nc    <= wr_nc;
            end else if (merge) begin
                for (int b = 0; b < WB_BE_W; b++) begin
                    if (wr_be[b]) q.data[8*b +: 8] <= wr_data[8*b +: 8];
                end
                q.be <= q.be | wr_be;
            end
            if (issue) q.state <= WB_SENT;
            if (ack)   q.state <= WB_FREE;
        end
    end

    assign entry       = q;
    assign merge_match = (q.state == WB_VALID) && !q.nc && (q.waddr == wr_waddr);
    assign chk_match   = (q.state != WB_FREE) && (q.waddr == chk_waddr);

endmodule

// File: rtl/wt_store_wbuf.sv
// Write-through store buffer: in-order issue, out-of-order ack retire, load hazard check.
// Optional macro WT_WBUF_MERGE_EN enables merging cacheable stores into a pending entry of the same word.
module wt_store_wbuf
    import wt_wbuf_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W,
    parameter int TID_W  = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ADDR_W-1:0]   req_paddr_i,
    input  logic [DATA_W-1:0]   req_data_i,
    input  logic [DATA_W/8-1:0] req_be_i,
    input  logic                req_nc_i,
    output logic                mem_valid_o,
    input  logic                mem_ready_i,
    output logic [ADDR_W-1:0]   mem_paddr_o,
    output logic [DATA_W-1:0]   mem_data_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic                mem_nc_o,
    output logic [TID_W-1:0]    mem_tid_o,
    input  logic                ack_valid_i,
    input  logic [TID_W-1:0]    ack_tid_i,
    input  logic [ADDR_W-1:0]   chk_paddr_i,
    output logic                chk_hit_o,
    output logic                empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wbuf_entry_t            ent [DEPTH];
    wbuf_entry_t            head;
    logic [DEPTH-1:0]       merge_match, merge_cand, chk_match;
    logic [DEPTH-1:0]       alloc_sel, merge_sel, issue_sel, ack_sel, is_free;
    logic [PTR_W-1:0]       tail_q, send_q;
    logic [WB_WADDR_W-1:0]  req_waddr, chk_waddr;
    logic                   merge_hit, accept, do_alloc, mem_fire;

    assign req_waddr = word_addr(req_paddr_i);
    assign chk_waddr = word_addr(chk_paddr_i);
    assign head      = ent[send_q];

`ifdef WT_WBUF_MERGE_EN
    assign merge_hit = req_valid_i && !req_nc_i && (|merge_cand);
`else
    assign merge_hit = 1'b0;
`endif

    // tail must be FREE to allocate, which keeps issue order equal to allocation order
    assign req_ready_o = merge_hit || (ent[tail_q].state == WB_FREE);
    assign accept      = req_valid_i && req_ready_o;
    assign do_alloc    = accept && !merge_hit && (|req_be_i);
    assign mem_valid_o = (head.state == WB_VALID);
    assign mem_fire    = mem_valid_o && mem_ready_i;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        // the entry on offer is frozen so mem_* stay stable until the handshake
        assign merge_cand[i] = merge_match[i] && !(mem_valid_o && send_q == PTR_W'(i));
        assign alloc_sel[i]  = do_alloc && (tail_q == PTR_W'(i));
        assign merge_sel[i]  = accept && merge_hit && merge_cand[i];
        assign issue_sel[i]  = mem_fire && (send_q == PTR_W'(i));
        assign ack_sel[i]    = ack_valid_i && (ack_tid_i == TID_W'(i)) && (ent[i].state == WB_SENT);
        assign is_free[i]    = (ent[i].state == WB_FREE);

        wt_wbuf_entry u_ent (
            .clk         (clk_i),
            .rst_n       (rst_ni),
            .alloc       (alloc_sel[i]),
            .merge       (merge_sel[i]),
            .issue       (issue_sel[i]),
            .ack         (ack_sel[i]),
            .wr_waddr    (req_waddr),
            .wr_data     (req_data_i),
            .wr_be       (req_be_i),
            .wr_nc       (req_nc_i),
            .chk_waddr   (chk_waddr),
            .entry       (ent[i]),
            .merge_match (merge_match[i]),
            .chk_match   (chk_match[i])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tail_q <= '0;
            send_q <= '0;
        end else begin
            if (do_alloc) tail_q <= (tail_q == PTR_W'(DEPTH-1)) ? '0 : tail_q + 1'b1;
            if (mem_fire) send_q <= (send_q == PTR_W'(DEPTH-1)) ? '0 : send_q + 1'b1;
        end
    end

    assign mem_paddr_o = {head.waddr, 3'b000};
    assign mem_data_o  = head.data;
    assign mem_be_o    = head.be;
    assign mem_nc_o    = head.nc;
    assign mem_tid_o   = TID_W'(send_q);
    assign chk_hit_o   = |chk_match;
    assign empty_o     = &is_free;

    // stray acks (e.g. left over from before a reset) are dropped by the ack_sel gating
    always @(posedge clk_i) begin
        if (rst_ni && ack_valid_i)
            assert (|ack_sel) else $warning("wt_store_wbuf: ack tid %0d not in flight, ignored", ack_tid_i);
    end

endmodule

// File: doc/wt_store_wbuf.md
# wt_store_wbuf

Write-through store buffer between the store unit and the write-through data-cache memory port. Holds up to DEPTH committed stores, merges cacheable byte-writes to the same 64-bit word, and issues them in order to the memory side with one transaction ID per entry. Entries retire on out-of-order write acknowledgements. It also flags load hazards against pending or in-flight stores, and reports emptiness for fences.

## Interface
- DEPTH, 2: entry count; must satisfy DEPTH <= 2**TID_W.
- ADDR_W, 34: physical address width.
- DATA_W, 64: store data width; BE width is DATA_W/8.
- TID_W, 2: memory transaction ID width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  committed store valid.
- req_ready_o  out  1  store accepted when valid&ready.
- req_paddr_i  in  ADDR_W  byte address; bits [2:0] ignored for matching.
- req_data_i  in  DATA_W  word-aligned store data.
- req_be_i  in  DATA_W/8  byte enables; all-zero stores are accepted and dropped.
- req_nc_i  in  1  non-cacheable store.
- mem_valid_o  out  1  write request valid.
- mem_ready_i  in  1  memory accepts request.
- mem_paddr_o  out  ADDR_W  word address, low 3 bits zero.
- mem_data_o  out  DATA_W  merged data.
- mem_be_o  out  DATA_W/8  merged byte enables.
- mem_nc_o  out  1  non-cacheable flag.
- mem_tid_o  out  TID_W  entry index.
- ack_valid_i  in  1  write acknowledge.
- ack_tid_i  in  TID_W  acknowledged entry.
- chk_paddr_i  in  ADDR_W  load address for hazard check.
- chk_hit_o  out  1  a non-FREE entry matches chk_paddr_i[ADDR_W-1:3].
- empty_o  out  1  all entries FREE.

## Operation
- Each entry has state FREE, VALID or SENT, plus word address, data, BE and nc.
- Pointers: tail_q (allocate) and send_q (issue) both advance circularly modulo DEPTH.
- Merge: an accepted store with nc=0 merges into a VALID entry when all of the following hold:
  - the entry has nc=0;
  - the word address is equal;
  - the entry is not being offered on mem (send_q with mem_valid_o=1).
- Merging writes each byte whose BE bit is set and ORs BE into the entry. At most one candidate can exist.
- Allocate: if there is no merge, the store is written into entry tail_q, provided it is FREE. The entry goes VALID and tail_q increments.
- req_ready_o = merge_hit | (state[tail_q]==FREE). It is combinational from registered state and the request.
- Issue: mem_valid_o = (state[send_q]==VALID). On mem_ready_i the entry goes SENT and send_q increments. mem_* fields are stable while valid and not ready.
- Ack: ack_valid_i moves entry ack_tid_i from SENT to FREE. Acks may arrive in any order. An ack to a non-SENT entry is ignored and triggers an assertion in simulation.
- Ordering is guaranteed because allocation stalls whenever the tail entry is still busy.
- empty_o = all FREE.
- chk_hit_o is combinational over VALID and SENT entries. It does not see a request in the current cycle.

## Timing
- Reset values: all entries FREE, pointers 0, mem_valid_o=0, req_ready_o=1, empty_o=1, chk_hit_o=0. Reset mid-transaction discards every entry; outstanding acks after reset are ignored.
- Store accepted in cycle N → entry VALID at N+1 → mem_valid_o at N+1 when it is at send_q. Minimum latency is 1 cycle.
- Full: all entries non-FREE with no merge hit → req_ready_o=0.
- Ack freeing tail_q in cycle N: req_ready_o rises at N+1, not N.
- Store whose merge target is handed off in the same cycle: merge is inhibited and a new entry is allocated if tail_q is FREE, else it stalls.
- Ack and issue in the same cycle act on different entries and both take effect.

## Configuration
- WT_WBUF_MERGE_EN defined: merging as above.
- Not defined: merge_hit is forced to 0, so every non-empty store allocates its own entry. All other behaviour is unchanged.

## Structure
- Package wt_wbuf_pkg holds:
  - wbuf_state_e {WB_FREE, WB_VALID, WB_SENT};
  - wbuf_entry_t (state, waddr, data, be, nc);
  - a function returning the word address.
- Sub-module wt_wbuf_entry: the per-entry state register, byte-merge datapath and address comparators, instantiated DEPTH times. The top level holds the pointers, ready/valid and the muxes.

## Test plan
- Store 0x8000_0000 BE=0x0F data=0x11223344, mem_ready_i=1 → mem_valid_o next cycle with tid 0, BE 0x0F; ack tid 0 → empty_o=1.
- mem_ready_i=0; store 0x8000_0010 BE=0x01, then 0x8000_0018 BE=0x01, then 0x8000_0018 BE=0x80:
  - with WT_WBUF_MERGE_EN, entry 1 has BE=0x81 and only 2 entries are used;
  - without it, the third store stalls (req_ready_o=0).
- Two nc=1 stores to 0x1000_0000 → two separate mem requests with tids 0 then 1; no merge.
- Fill both entries and issue both; ack tid 1 before tid 0 → entry 1 FREE while tail_q=0 still stalls; after ack tid 0, req_ready_o=1 the next cycle.
- Pending store to 0x8000_0020; chk_paddr_i=0x8000_0024 → chk_hit_o=1; chk_paddr_i=0x8000_0028 → 0.
- Assert rst_ni low with 2 entries SENT → all outputs at reset values; a later ack tid 0 is ignored and empty_o stays 1.
